dmem_responder: RTL and testbench

- Memory-side responder for the datapath's MEM-stage data accesses: accepts a word, halfword or byte load/store request over a valid/ready handshake, services it after a programmable latency and returns read data or status over a second valid/ready handshake.
- Replaces the zero-wait data memory, so the pipeline can stall on `req_ready` or `rsp_valid`.
- Performs byte-lane selection, store merging and load sign/zero extension internally.

---
 rtl/dmem_responder.sv | 218 +++++++++++++++++++++
 tb/tb_dmem_responder.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// MEM-stage data responder: valid/ready request and response handshakes around a
// word array, with programmable latency, byte-lane store merge and load extension.
module dmem_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [11:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int          AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] DEPTH_U  = 32'(DEPTH);
    localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_r;
    state_t      next_state_s;
    logic [3:0]  cnt_r;
    logic        hold_write_r;
    logic [11:0] hold_addr_r;
    logic [31:0] hold_wdata_r;
    logic [1:0]  hold_size_r;
    logic        hold_signed_r;
    logic        req_ready_r;
    logic        rsp_valid_r;
    logic [31:0] rsp_rdata_r;
    logic        rsp_err_r;
    logic        req_ready_s;
    logic        rsp_valid_s;
    logic [31:0] rsp_rdata_s;
    logic        rsp_err_s;
    logic        accept_s;
    logic        enter_resp_s;
    logic        rsp_fire_s;
    logic        hold_err_s;
    logic        mem_we_s;
    logic [AW-1:0] idx_s;
    logic [31:0] mem_word_s;
    logic [31:0] mem_r [DEPTH];

    function automatic logic access_err(input logic [1:0] size, input logic [1:0] lane);
        logic err;
        case (size)
            2'b00:   err = (lane != 2'b00);
            2'b01:   err = lane[0];
            2'b10:   err = 1'b0;
            default: err = 1'b1;
        endcase
        return err;
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] lane,
                                                 input logic [1:0] size, input logic sgn);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lane, 3'b000} +: 8];
        h = word[{lane[1], 4'b0000} +: 16];
        case (size)
            2'b00:   r = word;
            2'b01:   r = {{16{sgn & h[15]}}, h};
            2'b10:   r = {{24{sgn & b[7]}}, b};
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] wdata,
                                                input logic [1:0] lane, input logic [1:0] size);
        logic [31:0] r;
        r = word;
        case (size)
            2'b00:   r = wdata;
            2'b01:   r[{lane[1], 4'b0000} +: 16] = wdata[15:0];
            2'b10:   r[{lane, 3'b000} +: 8] = wdata[7:0];
            default: r = word;
        endcase
        return r;
    endfunction

    assign accept_s     = req_valid & req_ready_r & (state_r == IDLE);
    assign enter_resp_s = (state_r == WAIT) && (cnt_r == 4'd0);
    assign rsp_fire_s   = rsp_valid_r & rsp_ready;
    assign hold_err_s   = access_err(hold_size_r, hold_addr_r[1:0]);
    assign idx_s        = AW'({22'd0, hold_addr_r[11:2]} % DEPTH_U);
    assign mem_word_s   = mem_r[idx_s];
    // A reset landing on the commit edge discards the in-flight store.
    assign mem_we_s     = enter_resp_s & hold_write_r & ~hold_err_s & ~rst;

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic; every accept passes through WAIT, which with a zero
    // count lasts exactly one cycle and so gives LATENCY=1 its single-edge delay.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    next_state_s = WAIT;
                end else begin
                    next_state_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r == 4'd0) begin
                    next_state_s = RESP;
                end else begin
                    next_state_s = WAIT;
                end
            end
            RESP: begin
                if (rsp_fire_s) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = RESP;
                end
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Next values of the registered handshake and response outputs
    always_comb begin
        req_ready_s = (next_state_s == IDLE);
        rsp_valid_s = rsp_valid_r;
        rsp_rdata_s = rsp_rdata_r;
        rsp_err_s   = rsp_err_r;
        if (enter_resp_s) begin
            rsp_valid_s = 1'b1;
            rsp_err_s   = hold_err_s;
            if (hold_write_r || hold_err_s) begin
                rsp_rdata_s = 32'h0000_0000;
            end else begin
                rsp_rdata_s = load_extract(mem_word_s, hold_addr_r[1:0], hold_size_r, hold_signed_r);
            end
        end else if (rsp_fire_s) begin
            rsp_valid_s = 1'b0;
            rsp_rdata_s = 32'h0000_0000;
            rsp_err_s   = 1'b0;
        end else begin
            rsp_valid_s = rsp_valid_r;
            rsp_rdata_s = rsp_rdata_r;
            rsp_err_s   = rsp_err_r;
        end
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            req_ready_r <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 32'h0000_0000;
            rsp_err_r   <= 1'b0;
        end else begin
            req_ready_r <= req_ready_s;
            rsp_valid_r <= rsp_valid_s;
            rsp_rdata_r <= rsp_rdata_s;
            rsp_err_r   <= rsp_err_s;
        end
    end

    // Request holding registers and latency counter
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r         <= 4'd0;
            hold_write_r  <= 1'b0;
            hold_addr_r   <= 12'h000;
            hold_wdata_r  <= 32'h0000_0000;
            hold_size_r   <= 2'b00;
            hold_signed_r <= 1'b0;
        end else if (accept_s) begin
            cnt_r         <= CNT_LOAD;
            hold_write_r  <= req_write;
            hold_addr_r   <= req_addr;
            hold_wdata_r  <= req_wdata;
            hold_size_r   <= req_size;
            hold_signed_r <= req_signed;
        end else if ((state_r == WAIT) && (cnt_r != 4'd0)) begin
            cnt_r <= cnt_r - 4'd1;
        end
    end

    // Word array, read-modify-write on the edge entering RESP; never cleared
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[idx_s] <= store_merge(mem_word_s, hold_wdata_r, hold_addr_r[1:0], hold_size_r);
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed, table-driven bench for dmem_responder at LATENCY 2, 1 and 4.
module tb_dmem_responder;

    logic        clk;
    logic        rst;
    logic        req_write;
    logic [11:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_signed;
    logic        rsp_ready;
    logic        rv [3];
    logic        rr [3];
    logic        sv [3];
    logic [31:0] sd [3];
    logic        se [3];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        w;
        logic [11:0] a;
        logic [31:0] wd;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] ed;
        logic        ee;
    } vec_t;

    vec_t tbl[$];

    dmem_responder #(.DEPTH(1024), .LATENCY(2)) u_l2 (
        .clk(clk), .rst(rst), .req_valid(rv[0]), .req_ready(rr[0]), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size), .req_signed(req_signed),
        .rsp_valid(sv[0]), .rsp_ready(rsp_ready), .rsp_rdata(sd[0]), .rsp_err(se[0]));

    dmem_responder #(.DEPTH(1024), .LATENCY(1)) u_l1 (
        .clk(clk), .rst(rst), .req_valid(rv[1]), .req_ready(rr[1]), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size), .req_signed(req_signed),
        .rsp_valid(sv[1]), .rsp_ready(rsp_ready), .rsp_rdata(sd[1]), .rsp_err(se[1]));

    dmem_responder #(.DEPTH(64), .LATENCY(4)) u_l4 (
        .clk(clk), .rst(rst), .req_valid(rv[2]), .req_ready(rr[2]), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size), .req_signed(req_signed),
        .rsp_valid(sv[2]), .rsp_ready(rsp_ready), .rsp_rdata(sd[2]), .rsp_err(se[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic w, input logic [11:0] a, input logic [31:0] wd,
                                input logic [1:0] sz, input logic sg, input logic [31:0] ed,
                                input logic ee);
        vec_t v;
        v.w = w; v.a = a; v.wd = wd; v.sz = sz; v.sg = sg; v.ed = ed; v.ee = ee;
        return v;
    endfunction

    task automatic drive(input logic w, input logic [11:0] a, input logic [31:0] wd,
                         input logic [1:0] sz, input logic sg);
        req_write  = w;
        req_addr   = a;
        req_wdata  = wd;
        req_size   = sz;
        req_signed = sg;
    endtask

    // One complete transaction with rsp_ready held high; called #1 after an edge.
    task automatic do_req(input int d, input int lat, input logic w, input logic [11:0] a,
                          input logic [31:0] wd, input logic [1:0] sz, input logic sg,
                          input logic [31:0] ed, input logic ee, input string nm);
        int n;
        drive(w, a, wd, sz, sg);
        rv[d] = 1'b1;
        n = 0;
        while (!rr[d] && n < 20) begin
            tick();
            n++;
        end
        if (!rr[d]) begin
            rv[d] = 1'b0;
            chk1({nm, "_accept_timeout"}, rr[d], 1'b1);
            return;
        end
        tick();
        rv[d] = 1'b0;
        n = 0;
        while (!sv[d] && n < 40) begin
            tick();
            n++;
        end
        chk({nm, "_latency"}, n, lat);
        chk({nm, "_rdata"}, sd[d], ed);
        chk1({nm, "_err"}, se[d], ee);
        tick();
        chk1({nm, "_valid_cleared"}, sv[d], 1'b0);
        chk({nm, "_rdata_cleared"}, sd[d], 32'h0000_0000);
        chk1({nm, "_ready_after"}, rr[d], 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic stray;

        rst = 1'b1;
        rsp_ready = 1'b1;
        for (int d = 0; d < 3; d++) rv[d] = 1'b0;
        drive(1'b0, 12'h000, 32'h0, 2'b00, 1'b0);

        tbl.push_back(mk(1'b1, 12'h010, 32'hDEAD_BEEF, 2'b00, 1'b0, 32'h0000_0000, 1'b0));
        tbl.push_back(mk(1'b0, 12'h010, 32'h0,         2'b00, 1'b0, 32'hDEAD_BEEF, 1'b0));
        tbl.push_back(mk(1'b1, 12'h012, 32'hAAAA_AA7F, 2'b10, 1'b0, 32'h0000_0000, 1'b0));
        tbl.push_back(mk(1'b0, 12'h010, 32'h0,         2'b00, 1'b0, 32'hDE7F_BEEF, 1'b0));
        tbl.push_back(mk(1'b0, 12'h013, 32'h0,         2'b10, 1'b1, 32'hFFFF_FFDE, 1'b0));
        tbl.push_back(mk(1'b0, 12'h012, 32'h0,         2'b01, 1'b0, 32'h0000_DE7F, 1'b0));
        tbl.push_back(mk(1'b0, 12'h012, 32'h0,         2'b01, 1'b1, 32'hFFFF_DE7F, 1'b0));
        tbl.push_back(mk(1'b0, 12'h011, 32'h0,         2'b10, 1'b0, 32'h0000_00BE, 1'b0));
        tbl.push_back(mk(1'b0, 12'h011, 32'h0,         2'b01, 1'b0, 32'h0000_0000, 1'b1));
        tbl.push_back(mk(1'b0, 12'h012, 32'h0,         2'b00, 1'b0, 32'h0000_0000, 1'b1));
        tbl.push_back(mk(1'b1, 12'h012, 32'h1111_1111, 2'b00, 1'b0, 32'h0000_0000, 1'b1));
        tbl.push_back(mk(1'b1, 12'h013, 32'h0000_2222, 2'b01, 1'b0, 32'h0000_0000, 1'b1));
        tbl.push_back(mk(1'b1, 12'h010, 32'h3333_3333, 2'b11, 1'b0, 32'h0000_0000, 1'b1));
        tbl.push_back(mk(1'b0, 12'h010, 32'h0,         2'b11, 1'b0, 32'h0000_0000, 1'b1));
        tbl.push_back(mk(1'b0, 12'h010, 32'h0,         2'b00, 1'b0, 32'hDE7F_BEEF, 1'b0));
        tbl.push_back(mk(1'b1, 12'h010, 32'hFFFF_1234, 2'b01, 1'b0, 32'h0000_0000, 1'b0));
        tbl.push_back(mk(1'b0, 12'h010, 32'h0,         2'b00, 1'b1, 32'hDE7F_1234, 1'b0));
        tbl.push_back(mk(1'b0, 12'h011, 32'h0,         2'b10, 1'b1, 32'h0000_0012, 1'b0));
        tbl.push_back(mk(1'b1, 12'h020, 32'hCAFE_F00D, 2'b00, 1'b0, 32'h0000_0000, 1'b0));
        tbl.push_back(mk(1'b0, 12'h020, 32'h0,         2'b00, 1'b0, 32'hCAFE_F00D, 1'b0));

        // Power-on reset state
        tick();
        tick();
        for (int d = 0; d < 3; d++) begin
            chk1($sformatf("reset_ready%0d", d), rr[d], 1'b0);
            chk1($sformatf("reset_valid%0d", d), sv[d], 1'b0);
            chk($sformatf("reset_rdata%0d", d), sd[d], 32'h0000_0000);
            chk1($sformatf("reset_err%0d", d), se[d], 1'b0);
        end
        rst = 1'b0;
        tick();
        chk1("ready_after_reset", rr[0], 1'b1);

        for (int i = 0; i < tbl.size(); i++) begin
            do_req(0, 2, tbl[i].w, tbl[i].a, tbl[i].wd, tbl[i].sz, tbl[i].sg,
                   tbl[i].ed, tbl[i].ee, $sformatf("vec%0d", i));
        end

        // Back-pressure: response held for 5 cycles, request pulses ignored
        rsp_ready = 1'b0;
        drive(1'b0, 12'h010, 32'h0, 2'b00, 1'b0);
        rv[0] = 1'b1;
        tick();
        rv[0] = 1'b0;
        n = 0;
        while (!sv[0] && n < 20) begin
            tick();
            n++;
        end
        chk("hold_latency", n, 2);
        for (int i = 0; i < 5; i++) begin
            chk1("hold_valid", sv[0], 1'b1);
            chk("hold_rdata", sd[0], 32'hDE7F_1234);
            chk1("hold_err", se[0], 1'b0);
            chk1("hold_ready", rr[0], 1'b0);
            rv[0] = (i % 2 == 0) ? 1'b1 : 1'b0;
            drive(1'b1, 12'h010, 32'h5555_5555, 2'b00, 1'b0);
            tick();
        end
        rv[0] = 1'b0;
        rsp_ready = 1'b1;
        tick();
        chk1("release_valid", sv[0], 1'b0);
        chk1("release_ready", rr[0], 1'b1);
        stray = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            stray = stray | sv[0];
        end
        chk1("no_stray_response", stray, 1'b0);
        do_req(0, 2, 1'b0, 12'h010, 32'h0, 2'b00, 1'b0, 32'hDE7F_1234, 1'b0, "after_hold");

        // Reset while a store waits: no response, no commit
        drive(1'b1, 12'h020, 32'h1234_5678, 2'b00, 1'b0);
        rv[0] = 1'b1;
        tick();
        rv[0] = 1'b0;
        rst = 1'b1;
        tick();
        chk1("wait_rst_ready", rr[0], 1'b0);
        chk1("wait_rst_valid", sv[0], 1'b0);
        rst = 1'b0;
        stray = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            stray = stray | sv[0];
        end
        chk1("wait_rst_no_response", stray, 1'b0);
        chk1("wait_rst_ready_back", rr[0], 1'b1);
        do_req(0, 2, 1'b0, 12'h020, 32'h0, 2'b00, 1'b0, 32'hCAFE_F00D, 1'b0, "after_wait_rst");

        // Reset in RESP with rsp_ready low drops rsp_valid
        rsp_ready = 1'b0;
        drive(1'b0, 12'h020, 32'h0, 2'b00, 1'b0);
        rv[0] = 1'b1;
        tick();
        rv[0] = 1'b0;
        n = 0;
        while (!sv[0] && n < 20) begin
            tick();
            n++;
        end
        chk1("resp_rst_pre_valid", sv[0], 1'b1);
        rst = 1'b1;
        tick();
        chk1("resp_rst_valid", sv[0], 1'b0);
        chk("resp_rst_rdata", sd[0], 32'h0000_0000);
        rst = 1'b0;
        rsp_ready = 1'b1;
        tick();
        chk1("resp_rst_ready", rr[0], 1'b1);

        // LATENCY=1 build
        do_req(1, 1, 1'b1, 12'h040, 32'h0BAD_CAFE, 2'b00, 1'b0, 32'h0000_0000, 1'b0, "l1_store");
        do_req(1, 1, 1'b0, 12'h042, 32'h0, 2'b01, 1'b1, 32'h0000_0BAD, 1'b0, "l1_load");

        // LATENCY=4 build, DEPTH=64 so 0x100 aliases word 0
        do_req(2, 4, 1'b1, 12'h000, 32'h55AA_55AA, 2'b00, 1'b0, 32'h0000_0000, 1'b0, "l4_store");
        do_req(2, 4, 1'b0, 12'h100, 32'h0, 2'b00, 1'b0, 32'h55AA_55AA, 1'b0, "l4_alias_load");
        do_req(2, 4, 1'b0, 12'h103, 32'h0, 2'b10, 1'b1, 32'h0000_0055, 1'b0, "l4_byte_load");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
